// File: rtl/tile_seq_pkg.sv
// ----------------------------------------------------------------------------
// tile_seq_pkg : shared state encoding and width helper for tile_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tile_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Width of an anti-diagonal index for a tile x tile PE array.
  function automatic int diag_w(input int tile);
    return $clog2(2 * tile - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/skew_lane.sv
// ----------------------------------------------------------------------------
// skew_lane : DEPTH-stage data+valid shift chain feeding one array edge lane
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module skew_lane #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_vld,
  output logic [DW-1:0] out_data,
  output logic          out_vld
);

  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic [DEPTH-1:0]         vld_q, vld_d;

  always_comb begin
    data_d    = data_q;
    vld_d     = vld_q;
    data_d[0] = in_data;
    vld_d[0]  = in_vld;
    for (int s = 1; s < DEPTH; s++) begin
      data_d[s] = data_q[s-1];
      vld_d[s]  = vld_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign out_data = data_q[DEPTH-1];
  assign out_vld  = vld_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/tile_sequencer.sv
// ----------------------------------------------------------------------------
// tile_sequencer : skews A/B operand beats into a TILE x TILE systolic array,
//                  walks all output tiles and sequences anti-diagonal drains
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tile_sequencer
  import tile_seq_pkg::*;
#(
  parameter int TILE   = 2,
  parameter int DW     = 8,
  parameter int SIZE_W = 17,
  parameter int PE_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [SIZE_W-1:0]         size,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TILE*DW-1:0]        in_a,
  input  logic [TILE*DW-1:0]        in_b,
  output logic [TILE*DW-1:0]        a_out,
  output logic [TILE-1:0]           a_vld,
  output logic [TILE*DW-1:0]        b_out,
  output logic [TILE-1:0]           b_vld,
  output logic                      push_valid,
  output logic [diag_w(TILE)-1:0]   push_diag,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int DIAG_W    = diag_w(TILE);
  localparam int FLUSH_LEN = PE_LAT + 1;
  localparam int DRAIN_LEN = 2 * TILE - 1;
  localparam int PH_MAX    = (FLUSH_LEN > DRAIN_LEN) ? FLUSH_LEN : DRAIN_LEN;
  localparam int PH_W      = $clog2(PH_MAX);
  localparam int TW        = 2 * SIZE_W;

  localparam logic [SIZE_W-1:0] TILE_S     = SIZE_W'(TILE);
  localparam logic [PH_W-1:0]   FLUSH_LAST = PH_W'(FLUSH_LEN - 1);
  localparam logic [PH_W-1:0]   DRAIN_LAST = PH_W'(DRAIN_LEN - 1);

  state_t              state_q, state_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [SIZE_W-1:0]   k_cnt_q, k_cnt_d;
  logic [TW-1:0]       tiles_q, tiles_d;
  logic [TW-1:0]       tile_cnt_q, tile_cnt_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic                err_q, err_d;

  logic                beat;
  logic                size_ok;
  logic [SIZE_W-1:0]   quot;

  assign beat    = in_valid && (state_q == FEED);
  assign size_ok = (size >= TILE_S) && ((size % TILE_S) == '0);
  assign quot    = size / TILE_S;

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    k_cnt_d    = k_cnt_q;
    tiles_d    = tiles_q;
    tile_cnt_d = tile_cnt_q;
    phase_d    = phase_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (size_ok) begin
            // Tile total is fixed here so later tile compares ignore the live size input.
            size_d     = size;
            tiles_d    = TW'(quot) * TW'(quot);
            k_cnt_d    = '0;
            tile_cnt_d = '0;
            state_d    = FEED;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FEED: begin
        if (beat) begin
          if (k_cnt_q == size_q - SIZE_W'(1)) begin
            k_cnt_d = '0;
            phase_d = '0;
            state_d = FLUSH;
          end else begin
            k_cnt_d = k_cnt_q + SIZE_W'(1);
          end
        end
      end
      FLUSH: begin
        if (phase_q == FLUSH_LAST) begin
          phase_d = '0;
          state_d = DRAIN;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      DRAIN: begin
        if (phase_q == DRAIN_LAST) begin
          phase_d    = '0;
          tile_cnt_d = tile_cnt_q + TW'(1);
          state_d    = (tile_cnt_q + TW'(1) == tiles_q) ? DONE : FEED;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      size_q     <= '0;
      k_cnt_q    <= '0;
      tiles_q    <= '0;
      tile_cnt_q <= '0;
      phase_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      k_cnt_q    <= k_cnt_d;
      tiles_q    <= tiles_d;
      tile_cnt_q <= tile_cnt_d;
      phase_q    <= phase_d;
      err_q      <= err_d;
    end
  end

  assign in_ready   = (state_q == FEED);
  assign push_valid = (state_q == DRAIN);
  assign push_diag  = push_valid ? phase_q[DIAG_W-1:0] : '0;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign err        = err_q;

  // Lane i is i+1 stages deep; idle cycles push zero data with vld low.
  for (genvar i = 0; i < TILE; i++) begin : g_lane
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;

    assign a_in = beat ? in_a[i*DW +: DW] : '0;
    assign b_in = beat ? in_b[i*DW +: DW] : '0;

    skew_lane #(.DEPTH(i + 1), .DW(DW)) u_a_lane (
      .clk      (clk),
      .reset    (reset),
      .in_data  (a_in),
      .in_vld   (beat),
      .out_data (a_out[i*DW +: DW]),
      .out_vld  (a_vld[i])
    );

    skew_lane #(.DEPTH(i + 1), .DW(DW)) u_b_lane (
      .clk      (clk),
      .reset    (reset),
      .in_data  (b_in),
      .in_vld   (beat),
      .out_data (b_out[i*DW +: DW]),
      .out_vld  (b_vld[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_sequencer.sv
// ----------------------------------------------------------------------------
// tb_tile_sequencer : scoreboard bench for tile_sequencer (TILE=2 and TILE=4)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tile_sequencer;

  localparam int DW     = 8;
  localparam int SIZE_W = 17;
  localparam int PE_LAT = 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              dsel = 1'b0;
  logic [SIZE_W-1:0] size = '0;
  logic              in_valid = 1'b0;
  logic [4*DW-1:0]   in_a = '0;
  logic [4*DW-1:0]   in_b = '0;

  logic              ready2, pv2, busy2, done2, err2;
  logic [2*DW-1:0]   a_out2, b_out2;
  logic [1:0]        a_vld2, b_vld2;
  logic [1:0]        pd2;
  logic              ready4, pv4, busy4, done4, err4;
  logic [4*DW-1:0]   a_out4, b_out4;
  logic [3:0]        a_vld4, b_vld4;
  logic [2:0]        pd4;

  tile_sequencer #(.TILE(2), .DW(DW), .SIZE_W(SIZE_W), .PE_LAT(PE_LAT)) u_dut2 (
    .clk(clk), .reset(reset), .start(start && !dsel), .size(size),
    .in_valid(in_valid), .in_ready(ready2),
    .in_a(in_a[2*DW-1:0]), .in_b(in_b[2*DW-1:0]),
    .a_out(a_out2), .a_vld(a_vld2), .b_out(b_out2), .b_vld(b_vld2),
    .push_valid(pv2), .push_diag(pd2), .busy(busy2), .done(done2), .err(err2)
  );

  tile_sequencer #(.TILE(4), .DW(DW), .SIZE_W(SIZE_W), .PE_LAT(PE_LAT)) u_dut4 (
    .clk(clk), .reset(reset), .start(start && dsel), .size(size),
    .in_valid(in_valid), .in_ready(ready4),
    .in_a(in_a), .in_b(in_b),
    .a_out(a_out4), .a_vld(a_vld4), .b_out(b_out4), .b_vld(b_vld4),
    .push_valid(pv4), .push_diag(pd4), .busy(busy4), .done(done4), .err(err4)
  );

  always #5 clk = ~clk;

  // Active-instance view, widened to the 4-lane case
  logic            m_ready, m_pv, m_busy, m_done, m_err;
  logic [4*DW-1:0] m_a_out, m_b_out;
  logic [3:0]      m_a_vld, m_b_vld;
  logic [2:0]      m_pd;

  assign m_ready = dsel ? ready4 : ready2;
  assign m_pv    = dsel ? pv4    : pv2;
  assign m_busy  = dsel ? busy4  : busy2;
  assign m_done  = dsel ? done4  : done2;
  assign m_err   = dsel ? err4   : err2;
  assign m_a_out = dsel ? a_out4 : {16'h0, a_out2};
  assign m_b_out = dsel ? b_out4 : {16'h0, b_out2};
  assign m_a_vld = dsel ? a_vld4 : {2'b00, a_vld2};
  assign m_b_vld = dsel ? b_vld4 : {2'b00, b_vld2};
  assign m_pd    = dsel ? pd4    : {1'b0, pd2};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int            cyc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } lane_exp_t;

  typedef struct {
    int cyc;
    int d;
  } push_exp_t;

  lane_exp_t lane_q[4][$];
  push_exp_t push_q[$];
  int        done_q[$];
  int        err_q[$];

  int   edge_n = 0;
  logic mon_en = 1'b0;
  logic exp_busy = 1'b0;
  logic exp_ready = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [DW-1:0] fa(input int i, input int e);
    return {4'(i + 1), 4'(e)};
  endfunction

  function automatic logic [DW-1:0] fb(input int i, input int e);
    return {4'(i + 9), 4'(e)};
  endfunction

  task automatic set_data(input int e);
    for (int i = 0; i < 4; i++) begin
      in_a[i*DW +: DW] = fa(i, e);
      in_b[i*DW +: DW] = fb(i, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec cycle n is the clock period that ends at edge n.
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      int sc;
      int nl;
      logic ev;
      sc = edge_n + 1;
      nl = dsel ? 4 : 2;
      for (int i = 0; i < nl; i++) begin
        ev = (lane_q[i].size() > 0) && (lane_q[i][0].cyc == sc);
        check($sformatf("a_vld[%0d]@%0d", i, sc), m_a_vld[i], ev);
        check($sformatf("b_vld[%0d]@%0d", i, sc), m_b_vld[i], ev);
        if (ev) begin
          lane_exp_t x;
          x = lane_q[i].pop_front();
          check($sformatf("a_out[%0d]@%0d", i, sc), m_a_out[i*DW +: DW], x.a);
          check($sformatf("b_out[%0d]@%0d", i, sc), m_b_out[i*DW +: DW], x.b);
        end else begin
          check($sformatf("a_zero[%0d]@%0d", i, sc), m_a_out[i*DW +: DW], '0);
          check($sformatf("b_zero[%0d]@%0d", i, sc), m_b_out[i*DW +: DW], '0);
        end
      end
      ev = (push_q.size() > 0) && (push_q[0].cyc == sc);
      check($sformatf("push_valid@%0d", sc), m_pv, ev);
      if (ev) begin
        push_exp_t p;
        p = push_q.pop_front();
        check($sformatf("push_diag@%0d", sc), m_pd, p.d);
      end
      ev = (done_q.size() > 0) && (done_q[0] == sc);
      check($sformatf("done@%0d", sc), m_done, ev);
      if (ev) void'(done_q.pop_front());
      ev = (err_q.size() > 0) && (err_q[0] == sc);
      check($sformatf("err@%0d", sc), m_err, ev);
      if (ev) void'(err_q.pop_front());
      check($sformatf("busy@%0d", sc), m_busy, exp_busy);
      check($sformatf("in_ready@%0d", sc), m_ready, exp_ready);
    end
  end

  // Drives one full operation and records every expected output as it goes.
  task automatic run_op(input logic sel, input int sz, input int bub_at,
                        input int bub_len, input bit ign_start);
    int  t_w, ntiles, e, tl, beats, bub_done;
    bit  v;
    t_w      = sel ? 4 : 2;
    ntiles   = (sz / t_w) * (sz / t_w);
    e        = 0;
    tl       = 0;
    bub_done = 0;
    dsel     = sel;
    size     = SIZE_W'(sz);
    start    = 1'b1;
    in_valid = 1'b1;
    set_data(edge_n + 1);
    step();
    start     = 1'b0;
    exp_busy  = 1'b1;
    exp_ready = 1'b1;
    for (int t = 0; t < ntiles; t++) begin
      beats = 0;
      while (beats < sz) begin
        v = !(t == 0 && beats == bub_at && bub_done < bub_len);
        if (!v) bub_done++;
        in_valid = v;
        set_data(edge_n + 1);
        if (ign_start && t == 0 && beats == 1) begin
          start = 1'b1;
          size  = SIZE_W'(t_w);
        end else begin
          start = 1'b0;
        end
        step();
        e = edge_n;
        if (v) begin
          for (int i = 0; i < t_w; i++)
            lane_q[i].push_back('{cyc: e + 1 + i, a: fa(i, e), b: fb(i, e)});
          beats++;
        end
      end
      tl        = e;
      start     = 1'b0;
      exp_ready = 1'b0;
      for (int d = 0; d < 2 * t_w - 1; d++)
        push_q.push_back('{cyc: tl + PE_LAT + 2 + d, d: d});
      if (t == ntiles - 1) done_q.push_back(tl + PE_LAT + 2 * t_w + 1);
      while (edge_n < tl + PE_LAT + 2 * t_w) begin
        in_valid = 1'b1;
        set_data(edge_n + 1);
        step();
      end
      if (t < ntiles - 1) exp_ready = 1'b1;
    end
    step();
    exp_busy = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic bad_start(input logic sel, input int sz);
    dsel     = sel;
    size     = SIZE_W'(sz);
    start    = 1'b1;
    in_valid = 1'b1;
    set_data(edge_n + 1);
    step();
    err_q.push_back(edge_n + 1);
    start = 1'b0;
    repeat (4) step();
    in_valid = 1'b0;
  endtask

  initial begin
    int s;
    #1;
    check("rst_busy2",  busy2, 1'b0);
    check("rst_ready2", ready2, 1'b0);
    check("rst_vld2",   {a_vld2, b_vld2}, '0);
    check("rst_push2",  {pv2, pd2, done2, err2}, '0);
    check("rst_busy4",  busy4, 1'b0);
    check("rst_vld4",   {a_vld4, b_vld4, pv4}, '0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    step();
    mon_en = 1'b1;

    run_op(1'b0, 2, -1, 0, 1'b0);
    run_op(1'b0, 4, -1, 0, 1'b0);
    run_op(1'b1, 4, 2, 3, 1'b0);
    bad_start(1'b0, 3);
    bad_start(1'b0, 1);
    bad_start(1'b1, 6);
    run_op(1'b0, 4, -1, 0, 1'b1);

    // Async reset in the middle of a drain (diag 1 on screen)
    mon_en   = 1'b0;
    dsel     = 1'b0;
    size     = SIZE_W'(2);
    start    = 1'b1;
    in_valid = 1'b1;
    set_data(edge_n + 1);
    step();
    s     = edge_n;
    start = 1'b0;
    while (edge_n < s + 5) begin
      set_data(edge_n + 1);
      step();
    end
    check("pre_rst_push_valid", pv2, 1'b1);
    check("pre_rst_push_diag",  pd2, 2'd1);
    check("pre_rst_busy",       busy2, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_push", {pv2, pd2}, '0);
    check("async_rst_busy", busy2, 1'b0);
    check("async_rst_ready", ready2, 1'b0);
    check("async_rst_lanes", {a_vld2, b_vld2, a_out2, b_out2}, '0);
    check("async_rst_flags", {done2, err2}, '0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    in_valid  = 1'b0;
    exp_busy  = 1'b0;
    exp_ready = 1'b0;
    step();
    mon_en = 1'b1;
    run_op(1'b0, 2, -1, 0, 1'b0);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
